// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, issues word reads, and presents instr/PC to decode one instruction every 2 cycles.
// First id_valid arrives 2 cycles after reset release; while id_ready is low the held instruction stays stable and no read issues.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IADDR_W  = 10
) (
  input  logic               clk,
  input  logic               rst,
  output logic               im_rd,
  output logic [IADDR_W-1:0] im_addr,
  input  logic [31:0]        im_dout,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc,
  input  logic               redir_valid,
  input  logic [1:0]         redir_sel,
  input  logic [31:0]        redir_pc,
  input  logic [25:0]        redir_imm,
  input  logic [31:0]        redir_reg,
  output logic [31:0]        fetch_cnt
);

  typedef enum logic [1:0] {S_REQ, S_RESP, S_HOLD} state_t;

  state_t      state, nextState;
  logic [31:0] fetchPc;
  logic [31:0] pcPlus4;
  logic [31:0] branchOff;
  logic [31:0] target;
  logic        handshake;

  assign im_addr   = fetchPc[IADDR_W+1:2];
  assign handshake = id_valid && id_ready;

  always_comb begin
    pcPlus4   = redir_pc + 32'd4;
    branchOff = {{14{redir_imm[15]}}, redir_imm[15:0], 2'b00};
    target    = pcPlus4;
    unique case (redir_sel)
      2'b00:   target = pcPlus4 + branchOff;
      2'b01:   target = {pcPlus4[31:28], redir_imm, 2'b00};
      // jr: low bits of the register are dropped rather than trapped
      2'b10:   target = redir_reg & 32'hFFFF_FFFC;
      default: target = pcPlus4;
    endcase
  end

  always_comb begin
    nextState = state;
    im_rd     = 1'b0;
    unique case (state)
      S_REQ: begin
        nextState = S_RESP;
        im_rd     = 1'b1;
      end
      S_RESP: nextState = S_HOLD;
      S_HOLD: begin
        if (id_ready) begin
          nextState = S_RESP;
          im_rd     = 1'b1;
        end
      end
      default: nextState = S_REQ;
    endcase
    // a redirect kills any read issued this cycle and restarts at the target
    if (redir_valid) begin
      nextState = S_REQ;
      im_rd     = 1'b0;
    end
    if (rst) im_rd = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_REQ;
      fetchPc   <= RESET_PC;
      id_valid  <= 1'b0;
      id_instr  <= 32'd0;
      id_pc     <= 32'd0;
      fetch_cnt <= 32'd0;
    end else begin
      state <= nextState;
      if (handshake) fetch_cnt <= fetch_cnt + 32'd1;
      if (redir_valid) begin
        fetchPc  <= target;
        id_valid <= 1'b0;
      end else begin
        unique case (state)
          S_RESP: begin
            id_instr <= im_dout;
            id_pc    <= fetchPc;
            id_valid <= 1'b1;
            fetchPc  <= fetchPc + 32'd4;
          end
          S_HOLD: if (id_ready) id_valid <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed literal checks plus randomized traffic against a transaction-level model.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        im_rd;
  logic [9:0]  im_addr;
  logic [31:0] im_dout;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        redir_valid;
  logic [1:0]  redir_sel;
  logic [31:0] redir_pc;
  logic [25:0] redir_imm;
  logic [31:0] redir_reg;
  logic [31:0] fetch_cnt;

  int errors = 0;
  int checks = 0;
  bit chkOn  = 1'b0;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RESET_PC), .IADDR_W(10)) dut (
    .clk(clk), .rst(rst), .im_rd(im_rd), .im_addr(im_addr), .im_dout(im_dout),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .redir_valid(redir_valid), .redir_sel(redir_sel), .redir_pc(redir_pc),
    .redir_imm(redir_imm), .redir_reg(redir_reg), .fetch_cnt(fetch_cnt)
  );

  function automatic logic [31:0] memWord(input logic [9:0] a);
    return 32'h1000_0000 + {22'd0, a};
  endfunction

  // Memory returns data one cycle after a read; garbage otherwise so stale captures show up.
  always @(posedge clk) begin
    if (im_rd) im_dout <= memWord(im_addr);
    else       im_dout <= $urandom;
  end

  function automatic logic [31:0] redirTarget(input logic [1:0] sel, input logic [31:0] pc,
                                              input logic [25:0] imm, input logic [31:0] rv);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    case (sel)
      2'd0:    return p4 + 32'(int'($signed(imm[15:0])) * 4);
      2'd1:    return (p4 & 32'hF000_0000) | ({6'd0, imm} << 2);
      2'd2:    return rv & 32'hFFFF_FFFC;
      default: return p4;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction model: mReqNow = a read is due now, mRespNow = its data arrives now.
  logic [31:0] mPc, mInstr, mIdPc, mCnt;
  bit          mValid, mReqNow, mRespNow;

  always @(posedge clk) begin
    bit hs;
    if (rst) begin
      mPc = RESET_PC; mReqNow = 1; mRespNow = 0;
      mValid = 0; mInstr = 0; mIdPc = 0; mCnt = 0;
    end else begin
      hs = mValid && id_ready;
      if (hs) mCnt = mCnt + 1;
      if (redir_valid) begin
        mPc = redirTarget(redir_sel, redir_pc, redir_imm, redir_reg);
        mValid = 0; mReqNow = 1; mRespNow = 0;
      end else if (mRespNow) begin
        mInstr = memWord(mPc[11:2]); mIdPc = mPc; mValid = 1;
        mPc = mPc + 4; mRespNow = 0;
      end else if (mReqNow) begin
        mReqNow = 0; mRespNow = 1;
      end else if (hs) begin
        mValid = 0; mRespNow = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chkOn) begin
      check("im_rd", {31'd0, im_rd},
            {31'd0, !rst && !redir_valid && (mReqNow || (mValid && id_ready))});
      check("im_addr", {22'd0, im_addr}, {22'd0, mPc[11:2]});
      check("id_valid", {31'd0, id_valid}, {31'd0, mValid});
      check("fetch_cnt", fetch_cnt, mCnt);
      if (mValid) begin
        check("id_instr", id_instr, mInstr);
        check("id_pc", id_pc, mIdPc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitValid(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (id_valid) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: id_valid got 0 expected 1 within 20 cycles", name);
    end
  endtask

  task automatic redirect(input logic [1:0] sel, input logic [31:0] pc,
                          input logic [25:0] imm, input logic [31:0] rv);
    tick();
    redir_valid = 1; redir_sel = sel; redir_pc = pc; redir_imm = imm; redir_reg = rv;
    tick();
    redir_valid = 0;
  endtask

  initial begin
    logic [31:0] i0, p0, c0;
    rst = 1; id_ready = 0; redir_valid = 0; redir_sel = 0;
    redir_pc = 0; redir_imm = 0; redir_reg = 0;
    @(posedge clk);
    chkOn = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst id_valid", {31'd0, id_valid}, 32'd0);
    check("rst fetch_cnt", fetch_cnt, 32'd0);
    check("rst im_rd", {31'd0, im_rd}, 32'd0);
    check("rst id_pc", id_pc, 32'd0);
    check("rst id_instr", id_instr, 32'd0);

    // Release reset with decode always ready
    tick();
    rst = 0; id_ready = 1;
    tick();
    check("latency1 id_valid", {31'd0, id_valid}, 32'd0);
    tick();
    check("latency2 id_valid", {31'd0, id_valid}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      waitValid("seq valid");
      check("seq id_pc", id_pc, 32'(k * 4));
      check("seq id_instr", id_instr, 32'h1000_0000 + 32'(k));
      tick();
    end
    check("seq fetch_cnt", fetch_cnt, 32'd3);
    id_ready = 0;

    // Stall in hold
    waitValid("stall valid");
    i0 = id_instr; p0 = id_pc; c0 = fetch_cnt;
    repeat (5) begin
      @(negedge clk);
      check("stall id_valid", {31'd0, id_valid}, 32'd1);
      check("stall id_instr", id_instr, i0);
      check("stall id_pc", id_pc, p0);
      check("stall im_rd", {31'd0, im_rd}, 32'd0);
      check("stall fetch_cnt", fetch_cnt, c0);
    end

    // Branches
    redirect(2'd0, 32'h40, 26'h000FFFC, 32'd0);
    waitValid("br back valid");
    check("br back id_pc", id_pc, 32'h34);
    check("br back id_instr", id_instr, 32'h1000_000D);
    redirect(2'd0, 32'h40, 26'h0000003, 32'd0);
    waitValid("br fwd valid");
    check("br fwd id_pc", id_pc, 32'h50);
    check("br fwd id_instr", id_instr, 32'h1000_0014);

    // Jump and jr
    redirect(2'd1, 32'hF000_0010, 26'h0000100, 32'd0);
    @(negedge clk);
    check("j im_rd", {31'd0, im_rd}, 32'd1);
    check("j im_addr", {22'd0, im_addr}, 32'h100);
    waitValid("j valid");
    check("j id_pc", id_pc, 32'hF000_0400);
    check("j id_instr", id_instr, 32'h1000_0100);
    redirect(2'd2, 32'd0, 26'd0, 32'h0000_0123);
    waitValid("jr valid");
    check("jr id_pc", id_pc, 32'h120);
    check("jr id_instr", id_instr, 32'h1000_0048);

    // Redirect during the response cycle discards the returned word
    tick();
    id_ready = 1;
    tick();
    id_ready = 0;
    redir_valid = 1; redir_sel = 2'd3; redir_pc = 32'h200;
    tick();
    redir_valid = 0;
    waitValid("resp redir valid");
    check("resp redir id_pc", id_pc, 32'h204);
    check("resp redir id_instr", id_instr, 32'h1000_0081);

    // Redirect together with a handshake
    c0 = fetch_cnt;
    tick();
    id_ready = 1; redir_valid = 1; redir_sel = 2'd0; redir_pc = 32'h100; redir_imm = 26'd0;
    tick();
    id_ready = 0; redir_valid = 0;
    @(negedge clk);
    check("hs redir fetch_cnt", fetch_cnt, c0 + 32'd1);
    waitValid("hs redir valid");
    check("hs redir id_pc", id_pc, 32'h104);
    check("hs redir fetch_cnt2", fetch_cnt, c0 + 32'd1);

    // Reset pulse while holding
    tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    check("rpulse id_valid", {31'd0, id_valid}, 32'd0);
    check("rpulse fetch_cnt", fetch_cnt, 32'd0);
    check("rpulse im_rd", {31'd0, im_rd}, 32'd1);
    check("rpulse im_addr", {22'd0, im_addr}, {22'd0, RESET_PC[11:2]});

    // Random traffic
    repeat (3000) begin
      tick();
      rst         = ($urandom_range(0, 199) == 0);
      redir_valid = ($urandom_range(0, 7) == 0);
      redir_sel   = 2'($urandom);
      redir_pc    = $urandom;
      redir_imm   = 26'($urandom);
      redir_reg   = $urandom;
      id_ready    = 1'($urandom_range(0, 1));
    end
    tick();
    rst = 0; redir_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction fetch stage placed directly upstream of the decode/register-file/ALU datapath. Owns the architectural PC and drives the synchronous word-addressed instruction memory, which returns data one cycle after a read. Presents each fetched instruction and its PC to decode through a valid/ready handshake. Accepts branch, jump and jr redirects from downstream and computes the next PC from them.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
IADDR_W, 10, instruction memory word-address width (1024 words, 4 KB).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, synchronous, active-high.
im_rd  out  1  instruction memory read strobe.
im_addr  out  IADDR_W  word address, equal to pc[IADDR_W+1:2].
im_dout  in  32  read data, valid in the cycle after im_rd.
id_valid  out  1  id_instr and id_pc are valid.
id_ready  in  1  decode accepts the instruction.
id_instr  out  32  fetched instruction.
id_pc  out  32  byte address of id_instr.
redir_valid  in  1  single-cycle redirect request.
redir_sel  in  2  00 branch, 01 j/jal, 10 jr, 11 sequential.
redir_pc  in  32  PC of the redirecting instruction.
redir_imm  in  26  bits [15:0] hold the branch offset; all 26 bits hold the jump index.
redir_reg  in  32  register value for jr.
fetch_cnt  out  32  count of completed id handshakes.

Behaviour:
- Internal state is a register fetch_pc plus FSM state {S_REQ, S_RESP, S_HOLD}.
- Reset (rst high at a clock edge) sets fetch_pc=RESET_PC, state=S_REQ, id_valid=0, id_instr=0, id_pc=0, fetch_cnt=0.
- While rst is high, im_rd is forced to 0.
- im_rd is combinational: im_rd = !rst && !redir_valid && (state==S_REQ || (state==S_HOLD && id_ready)).
- im_addr always equals fetch_pc[IADDR_W+1:2]. Higher address bits are ignored, so the address wraps modulo 4 KB.
- S_REQ: im_rd=1. Next state is S_RESP.
- S_RESP: at the clock edge, id_instr<=im_dout, id_pc<=fetch_pc, id_valid<=1, fetch_pc<=fetch_pc+4 (mod 2^32). Next state is S_HOLD. id_valid is 0 during S_RESP.
- S_HOLD: id_valid=1 and the outputs are held stable.
  - If id_ready is high: fetch_cnt increments, im_rd=1 for the new fetch_pc, id_valid<=0, next state is S_RESP.
  - Otherwise the FSM stays in S_HOLD.
- Throughput is one instruction per 2 cycles. Latency from reset release to the first id_valid is 2 cycles.
- redir_valid has priority over all FSM actions, in any state:
  - fetch_pc <= target, id_valid <= 0, next state is S_REQ, im_rd=0 that cycle.
  - A response arriving that cycle (S_RESP) is discarded.
- Simultaneous redirect and handshake (S_HOLD, id_valid & id_ready & redir_valid): the handshake completes, fetch_cnt increments, then the redirect applies.
- Target computation, with p4 = redir_pc+4:
  - 00: p4 + (sign-extended redir_imm[15:0] << 2).
  - 01: {p4[31:28], redir_imm, 2'b00}.
  - 10: {redir_reg[31:2], 2'b00}. The low bits are silently cleared.
  - 11: p4.
- All address arithmetic is 32-bit and wraps modulo 2^32.
- fetch_cnt wraps from 32'hFFFF_FFFF to 0.
- Reset asserted mid-operation, including in S_RESP or with a pending redirect, overrides everything. The next state is S_REQ at RESET_PC.

Test Plan:
- Reset, then id_ready=1 held, memory word k = 32'h1000_0000+k → id_pc sequence 0,4,8 with id_instr 1000_0000,1000_0001,1000_0002; id_valid first high 2 cycles after rst falls; fetch_cnt=3 after 3 handshakes.
- id_ready=0 for 5 cycles in S_HOLD → id_valid, id_instr and id_pc stable; im_rd=0; fetch_cnt unchanged.
- Branch redirect with redir_sel=00, redir_pc=0x40, imm=16'hFFFC → next id_pc=0x34. With imm=16'h0003 → next id_pc=0x50.
- Jump redirect with redir_sel=01, redir_pc=0xF000_0010, imm=26'h0000100 → next id_pc=0xF000_0400, im_addr=10'h100. Jr with redir_reg=0x0000_0123 → next id_pc=0x120.
- Redirect asserted in S_RESP → returned word never appears on id_instr. Redirect together with a handshake in S_HOLD → fetch_cnt increments once, next id_pc=target.
- rst pulsed during S_HOLD with id_valid=1 → next cycle id_valid=0, fetch_cnt=0, im_rd=1 with im_addr=RESET_PC[11:2].
